// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - CPU data SRAM responder with RAM and config registers (LED, switch, scratch, timer)
module data_sram_responder #(
  parameter int          RAM_AWIDTH   = 14,
  parameter logic [15:0] CONF_BASE_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_SCRATCH = 16'hF010;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_CMP     = 16'hE004;
  localparam logic [15:0] OFF_STAT    = 16'hE008;

  logic [31:0] mem [0:(1<<RAM_AWIDTH)-1];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  logic                  is_conf, rd, wr, conf_wr, ram_wr;
  logic [15:0]           off;
  logic [RAM_AWIDTH-1:0] idx;
  logic [31:0]           conf_rdata;
  logic                  match;

  assign is_conf = (data_sram_addr[31:16] == CONF_BASE_HI);
  assign off     = data_sram_addr[15:0];
  assign idx     = data_sram_addr[RAM_AWIDTH+1:2];
  assign rd      = data_sram_en && (data_sram_wen == 4'h0);
  assign wr      = data_sram_en && (data_sram_wen != 4'h0);
  assign conf_wr = wr && is_conf;
  assign ram_wr  = wr && !is_conf;
  // Compare uses the pre-update timer value, so a TIMER write this cycle does not affect it
  assign match   = (timer_q == cmp_q) && (cmp_q != 32'h0);

  always_comb begin
    conf_rdata = 32'h0;
    case (off)
      OFF_LED:     conf_rdata = {16'h0, led_q};
      OFF_SWITCH:  conf_rdata = {24'h0, sw_sync_q};
      OFF_SCRATCH: conf_rdata = scratch_q;
      OFF_TIMER:   conf_rdata = timer_q;
      OFF_CMP:     conf_rdata = cmp_q;
      OFF_STAT:    conf_rdata = {31'h0, flag_q};
      default:     conf_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d   = rdata_q;
    led_d     = led_q;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'h1;
    cmp_d     = cmp_q;
    flag_d    = flag_q;
    if (rd) rdata_d = is_conf ? conf_rdata : mem[idx];
    if (conf_wr) begin
      case (off)
        OFF_LED:     led_d     = data_sram_wdata[15:0];
        OFF_SCRATCH: scratch_d = data_sram_wdata;
        OFF_TIMER:   timer_d   = data_sram_wdata;
        OFF_CMP:     cmp_d     = data_sram_wdata;
        OFF_STAT:    if (data_sram_wdata[0]) flag_d = 1'b0;
        default:     ;
      endcase
    end
    if (match) flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      scratch_q <= 32'h0;
      timer_q   <= 32'h0;
      cmp_q     <= 32'h0;
      flag_q    <= 1'b0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      scratch_q <= scratch_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      flag_q    <= flag_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign timer_irq       = flag_q;

endmodule
